// File: rtl/ds_tx_sched.sv
// rtl/ds_tx_sched.sv - IEEE 1355 DS link transmit character scheduler
module ds_tx_sched #(
  parameter int DW             = 8,
  parameter int CREDIT_PER_FCT = 8,
  parameter int CREDIT_MAX     = 56,
  parameter int CW             = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          link_en,
  input  logic          req0,
  input  logic [DW-1:0] data0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [DW-1:0] data1,
  output logic          gnt1,
  input  logic          fct_req,
  output logic          fct_ack,
  input  logic          rx_fct,
  input  logic          tx_rdy,
  output logic          tx_vld,
  output logic [1:0]    tx_type,
  output logic [DW-1:0] tx_data,
  output logic [CW-1:0] credit,
  output logic          credit_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} stateT;

  localparam logic [1:0] TYPE_NULL = 2'b00;
  localparam logic [1:0] TYPE_FCT  = 2'b01;
  localparam logic [1:0] TYPE_DATA = 2'b10;

  localparam logic [CW:0] CREDIT_INC = (CW+1)'(CREDIT_PER_FCT);
  localparam logic [CW:0] CREDIT_TOP = (CW+1)'(CREDIT_MAX);

  stateT state;
  stateT nextState;

  // Round-robin pointer: 0 gives requester 0 priority, 1 gives requester 1
  logic ptr;

  logic          slotFree;
  logic          doLoad;
  logic          elig0;
  logic          elig1;
  logic          pickFct;
  logic          pickData;
  logic          winner1;
  logic          fctIn;
  logic [1:0]    loadType;
  logic [DW-1:0] loadData;
  logic [CW:0]   creditDec;
  logic [CW:0]   creditSum;
  logic [CW-1:0] creditNext;
  logic          errNext;

  // State register: tracks whether the link is up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state: link_en alone decides IDLE versus RUN
  always_comb begin
    nextState = state;
    if (link_en) begin
      nextState = RUN;
    end else begin
      nextState = IDLE;
    end
  end

  // Load selection and credit arithmetic for the coming edge
  always_comb begin
    slotFree = !tx_vld || tx_rdy;
    doLoad   = link_en && slotFree;
    // A grant/ack still high this cycle means the requester has not yet
    // retired that character, so it must not be picked again.
    elig0    = req0 && !gnt0;
    elig1    = req1 && !gnt1;
    pickFct  = doLoad && fct_req && !fct_ack;
    pickData = doLoad && !pickFct && (credit != '0) && (elig0 || elig1);
    winner1  = elig1 && (!elig0 || ptr);

    loadType = TYPE_NULL;
    loadData = '0;
    if (pickFct) begin
      loadType = TYPE_FCT;
    end else if (pickData) begin
      loadType = TYPE_DATA;
      loadData = winner1 ? data1 : data0;
    end

    // Credit is consumed at commit; an FCT that would push past the
    // ceiling is dropped and flagged, the decrement still stands.
    creditDec  = {1'b0, credit} - {{CW{1'b0}}, pickData};
    creditSum  = creditDec + CREDIT_INC;
    fctIn      = (state == RUN) && rx_fct;
    creditNext = creditDec[CW-1:0];
    errNext    = credit_err;
    if (fctIn) begin
      if (creditSum > CREDIT_TOP) begin
        errNext = 1'b1;
      end else begin
        creditNext = creditSum[CW-1:0];
      end
    end
  end

  // Output register, pulses, pointer and credit; link drop clears everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_vld     <= 1'b0;
      tx_type    <= TYPE_NULL;
      tx_data    <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      fct_ack    <= 1'b0;
      credit     <= '0;
      credit_err <= 1'b0;
      ptr        <= 1'b0;
    end else if (!link_en) begin
      tx_vld     <= 1'b0;
      tx_type    <= TYPE_NULL;
      tx_data    <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      fct_ack    <= 1'b0;
      credit     <= '0;
      credit_err <= 1'b0;
      ptr        <= 1'b0;
    end else begin
      gnt0       <= pickData && !winner1;
      gnt1       <= pickData && winner1;
      fct_ack    <= pickFct;
      credit     <= creditNext;
      credit_err <= errNext;
      if (doLoad) begin
        tx_vld  <= 1'b1;
        tx_type <= loadType;
        tx_data <= loadData;
      end
      if (pickData) begin
        ptr <= !winner1;
      end
    end
  end

endmodule

// File: tb/tb_ds_tx_sched.sv
// tb/tb_ds_tx_sched.sv - directed table-driven bench for ds_tx_sched
module tb_ds_tx_sched;

  localparam int DW = 8;
  localparam int CW = 6;

  logic          clk;
  logic          rst_n;
  logic          link_en;
  logic          req0;
  logic [DW-1:0] data0;
  logic          gnt0;
  logic          req1;
  logic [DW-1:0] data1;
  logic          gnt1;
  logic          fct_req;
  logic          fct_ack;
  logic          rx_fct;
  logic          tx_rdy;
  logic          tx_vld;
  logic [1:0]    tx_type;
  logic [DW-1:0] tx_data;
  logic [CW-1:0] credit;
  logic          credit_err;

  int checks;
  int failures;

  ds_tx_sched #(.DW(DW), .CREDIT_PER_FCT(8), .CREDIT_MAX(56), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .link_en(link_en),
    .req0(req0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .data1(data1), .gnt1(gnt1),
    .fct_req(fct_req), .fct_ack(fct_ack), .rx_fct(rx_fct),
    .tx_rdy(tx_rdy), .tx_vld(tx_vld), .tx_type(tx_type), .tx_data(tx_data),
    .credit(credit), .credit_err(credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          le;
    logic          r0;
    logic [DW-1:0] d0;
    logic          r1;
    logic [DW-1:0] d1;
    logic          fr;
    logic          rf;
    logic          rdy;
    logic [20:0]   exp;
  } vecT;

  vecT vecs[$];

  function automatic vecT mk(input logic le, input logic r0, input logic [7:0] d0,
                             input logic r1, input logic [7:0] d1, input logic fr,
                             input logic rf, input logic rdy, input logic vld,
                             input logic [1:0] typ, input logic [7:0] dat,
                             input logic g0, input logic g1, input logic fa,
                             input logic [5:0] cr, input logic err);
    vecT v;
    v.le = le; v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1;
    v.fr = fr; v.rf = rf; v.rdy = rdy;
    v.exp = {vld, typ, dat, g0, g1, fa, cr, err};
    return v;
  endfunction

  function automatic logic [20:0] outVec();
    return {tx_vld, tx_type, tx_data, gnt0, gnt1, fct_ack, credit, credit_err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nGnt;
    checks = 0;
    failures = 0;
    rst_n = 1'b0; link_en = 1'b0; req0 = 1'b0; data0 = '0; req1 = 1'b0; data1 = '0;
    fct_req = 1'b0; rx_fct = 1'b0; tx_rdy = 1'b0;

    //      le r0 d0     r1 d1     fr rf rdy  vld typ dat    g0 g1 fa cr  err
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 2'd0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 2'd0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'hA5, 0, 8'h00, 0, 0, 1, 1, 2'd0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'hA5, 0, 8'h00, 0, 0, 1, 1, 2'd0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'hA5, 0, 8'h00, 0, 0, 1, 1, 2'd0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'hA5, 0, 8'h00, 0, 1, 1, 1, 2'd0, 8'h00, 0, 0, 0, 8, 0));
    vecs.push_back(mk(1, 1, 8'hA5, 0, 8'h00, 0, 0, 1, 1, 2'd2, 8'hA5, 1, 0, 0, 7, 0));
    vecs.push_back(mk(1, 1, 8'hA5, 0, 8'h00, 0, 0, 1, 1, 2'd0, 8'h00, 0, 0, 0, 7, 0));
    vecs.push_back(mk(1, 1, 8'h11, 1, 8'h21, 0, 0, 1, 1, 2'd2, 8'h21, 0, 1, 0, 6, 0));
    vecs.push_back(mk(1, 1, 8'h11, 1, 8'h21, 0, 0, 1, 1, 2'd2, 8'h11, 1, 0, 0, 5, 0));
    vecs.push_back(mk(1, 1, 8'h11, 1, 8'h22, 0, 0, 1, 1, 2'd2, 8'h22, 0, 1, 0, 4, 0));
    vecs.push_back(mk(1, 1, 8'h12, 1, 8'h22, 0, 0, 1, 1, 2'd2, 8'h12, 1, 0, 0, 3, 0));
    vecs.push_back(mk(1, 1, 8'h12, 1, 8'h23, 0, 0, 1, 1, 2'd2, 8'h23, 0, 1, 0, 2, 0));
    vecs.push_back(mk(1, 1, 8'h13, 1, 8'h23, 0, 0, 1, 1, 2'd2, 8'h13, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 8'h13, 1, 8'h24, 0, 0, 1, 1, 2'd2, 8'h24, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h14, 1, 8'h24, 0, 0, 1, 1, 2'd0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h14, 1, 8'h24, 0, 0, 1, 1, 2'd0, 8'h00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 1, 1, 1, 2'd0, 8'h00, 0, 0, 0, 8, 0));
    vecs.push_back(mk(1, 1, 8'h5A, 0, 8'h00, 1, 0, 1, 1, 2'd1, 8'h00, 0, 0, 1, 8, 0));
    vecs.push_back(mk(1, 1, 8'h5A, 0, 8'h00, 0, 0, 0, 1, 2'd1, 8'h00, 0, 0, 0, 8, 0));
    vecs.push_back(mk(1, 1, 8'h5A, 0, 8'h00, 0, 0, 0, 1, 2'd1, 8'h00, 0, 0, 0, 8, 0));
    vecs.push_back(mk(1, 1, 8'h5A, 0, 8'h00, 0, 0, 0, 1, 2'd1, 8'h00, 0, 0, 0, 8, 0));
    vecs.push_back(mk(1, 1, 8'h5A, 0, 8'h00, 0, 0, 0, 1, 2'd1, 8'h00, 0, 0, 0, 8, 0));
    vecs.push_back(mk(1, 1, 8'h5A, 0, 8'h00, 0, 0, 1, 1, 2'd2, 8'h5A, 1, 0, 0, 7, 0));
    vecs.push_back(mk(1, 1, 8'h5A, 0, 8'h00, 0, 0, 1, 1, 2'd0, 8'h00, 0, 0, 0, 7, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 2'd0, 8'h00, 0, 0, 0, 7, 0));

    // Reset state
    tick();
    tick();
    chk("reset_outputs", {11'b0, outVec()}, 32'h0);
    rst_n = 1'b1;

    // Table: idle NULLs, credit gating, alternation, FCT priority and stall
    for (int i = 0; i < vecs.size(); i++) begin
      link_en = vecs[i].le; req0 = vecs[i].r0; data0 = vecs[i].d0;
      req1 = vecs[i].r1; data1 = vecs[i].d1; fct_req = vecs[i].fr;
      rx_fct = vecs[i].rf; tx_rdy = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d", i), {11'b0, outVec()}, {11'b0, vecs[i].exp});
    end
    req0 = 1'b0; req1 = 1'b0; fct_req = 1'b0; rx_fct = 1'b0;

    // Link drop clears credit, then seven FCTs fill to the ceiling
    link_en = 1'b0;
    tick();
    chk("drop1_vld", tx_vld, 0);
    chk("drop1_credit", credit, 0);
    link_en = 1'b1; tx_rdy = 1'b1;
    tick();
    chk("rerun_null", {tx_vld, tx_type}, {1'b1, 2'd0});
    for (int i = 0; i < 7; i++) begin
      rx_fct = 1'b1;
      tick();
    end
    rx_fct = 1'b0;
    chk("fill_credit", credit, 56);
    chk("fill_err", credit_err, 0);
    rx_fct = 1'b1;
    tick();
    rx_fct = 1'b0;
    chk("ovf_credit", credit, 56);
    chk("ovf_err", credit_err, 1);

    // Drop clears the sticky flag; rebuild and hit same-edge overflow at 50
    link_en = 1'b0;
    tick();
    chk("drop2_credit", credit, 0);
    chk("drop2_err", credit_err, 0);
    link_en = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      rx_fct = 1'b1;
      tick();
    end
    rx_fct = 1'b0;
    req0 = 1'b1; data0 = 8'h77;
    nGnt = 0;
    for (int k = 0; k < 40 && nGnt < 6; k++) begin
      tick();
      if (gnt0) nGnt++;
    end
    chk("six_grants", nGnt, 6);
    chk("credit_50", credit, 50);
    tick();
    chk("masked_null", {tx_type, credit}, {2'd0, 6'd50});
    rx_fct = 1'b1;
    tick();
    rx_fct = 1'b0;
    chk("same_edge_type", {tx_type, tx_data, gnt0}, {2'd2, 8'h77, 1'b1});
    chk("same_edge_credit", credit, 49);
    chk("same_edge_err", credit_err, 1);

    // Link drop with DATA pending and stalled encoder
    tx_rdy = 1'b0;
    link_en = 1'b0;
    tick();
    chk("drop3_outputs", {11'b0, outVec()}, 32'h0);
    link_en = 1'b1; req0 = 1'b0;
    tick();
    chk("rerun_null2", {tx_vld, tx_type, gnt0, gnt1}, {1'b1, 2'd0, 1'b0, 1'b0});
    rx_fct = 1'b1; tx_rdy = 1'b1;
    tick();
    rx_fct = 1'b0;
    chk("rerun_credit", credit, 8);
    req0 = 1'b1; data0 = 8'hC0; req1 = 1'b1; data1 = 8'hC1;
    tick();
    chk("ptr_reset_req0", {tx_type, tx_data, gnt0, gnt1, credit},
        {2'd2, 8'hC0, 1'b1, 1'b0, 6'd7});

    // Asynchronous reset mid-run
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {11'b0, outVec()}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
